// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN readout path.
package snn_pkg;

    localparam int unsigned DefTimerWidth = 5;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StScan,
        StDone
    } readout_state_e;

    // LSB position of accumulator element idx in the flattened counts bus.
    function automatic int unsigned count_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/readout_argmax_scan.sv
// Serial argmax over the flattened accumulator counts, one element per cycle.
// Optional tie flag is built when SPIKE_READOUT_TIE_EN is defined.
module readout_argmax_scan
    import snn_pkg::*;
#(
    parameter int unsigned NUM_OUT     = 10,
    parameter int unsigned TIMER_WIDTH = DefTimerWidth,
    parameter int unsigned IDX_WIDTH   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           scan_start,
    input  logic                           scan_en,
    input  logic [NUM_OUT*TIMER_WIDTH-1:0] counts,
    output logic                           scan_done,
    output logic [IDX_WIDTH-1:0]           max_idx,
    output logic [TIMER_WIDTH-1:0]         max_count
`ifdef SPIKE_READOUT_TIE_EN
    ,
    output logic                           max_tie
`endif
);

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_OUT - 1);

    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [TIMER_WIDTH-1:0] max_q, max_d;
    logic [TIMER_WIDTH-1:0] cur;
    int unsigned            lsb;
    logic                   tie_q, tie_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
            idx_q <= '0;
            max_q <= '0;
            tie_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            max_q <= max_d;
            tie_q <= tie_d;
        end
    end

    always_comb begin
        lsb   = count_lsb(32'(cnt_q), TIMER_WIDTH);
        cur   = counts[lsb +: TIMER_WIDTH];
        cnt_d = cnt_q;
        idx_d = idx_q;
        max_d = max_q;
        tie_d = tie_q;
        if (scan_start) begin
            cnt_d = '0;
        end else if (scan_en) begin
            cnt_d = (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) begin
                max_d = cur;
                idx_d = '0;
                tie_d = 1'b0;
            end else if (cur > max_q) begin
                // Strict compare keeps the lowest index on ties.
                max_d = cur;
                idx_d = cnt_q;
                tie_d = 1'b0;
            end else if (cur == max_q) begin
                tie_d = 1'b1;
            end
        end
    end

    assign scan_done = scan_en && (cnt_q == LastIdx);
    assign max_idx   = idx_q;
    assign max_count = max_q;
`ifdef SPIKE_READOUT_TIE_EN
    assign max_tie   = tie_q;
`endif

endmodule

// File: rtl/spike_count_readout.sv
// Readout controller: clear accumulators, open spike window, argmax scan, valid/ready result.
// Define SPIKE_READOUT_TIE_EN to add the class_tie output.
module spike_count_readout
    import snn_pkg::*;
#(
    parameter int unsigned NUM_OUT     = 10,
    parameter int unsigned TIMER_WIDTH = DefTimerWidth,
    parameter int unsigned WINDOW      = 16,
    parameter int unsigned IDX_WIDTH   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [NUM_OUT*TIMER_WIDTH-1:0] counts,
    output logic                           acc_clr_n,
    output logic                           window_active,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_WIDTH-1:0]           class_idx,
    output logic [TIMER_WIDTH-1:0]         class_count
`ifdef SPIKE_READOUT_TIE_EN
    ,
    output logic                           class_tie
`endif
);

    readout_state_e         state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   scan_start;
    logic                   scan_en;
    logic                   scan_done;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StClear;
            StClear: begin
                timer_d = TIMER_WIDTH'(WINDOW - 1);
                state_d = StRun;
            end
            StRun: begin
                if (timer_q == '0) state_d = StScan;
                else               timer_d = timer_q - 1'b1;
            end
            StScan:  if (scan_done) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // Accumulators stay cleared while the block itself is in reset.
        acc_clr_n     = rstn && (state_q != StClear);
        window_active = (state_q == StRun);
        busy          = (state_q != StIdle);
        out_valid     = (state_q == StDone);
        scan_start    = (state_q == StRun) && (timer_q == '0);
        scan_en       = (state_q == StScan);
    end

    readout_argmax_scan #(
        .NUM_OUT     (NUM_OUT),
        .TIMER_WIDTH (TIMER_WIDTH),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_scan (
        .clk        (clk),
        .rstn       (rstn),
        .scan_start (scan_start),
        .scan_en    (scan_en),
        .counts     (counts),
        .scan_done  (scan_done),
        .max_idx    (class_idx),
        .max_count  (class_count)
`ifdef SPIKE_READOUT_TIE_EN
        ,
        .max_tie    (class_tie)
`endif
    );

endmodule

// File: tb/tb_spike_count_readout.sv
// Directed bench for spike_count_readout with NUM_OUT=4, WINDOW=8, TIMER_WIDTH=5.
module tb_spike_count_readout;

    localparam int unsigned NumOut = 4;
    localparam int unsigned Tw     = 5;
    localparam int unsigned Win    = 8;
    localparam int unsigned Iw     = 2;

    logic              clk;
    logic              rstn;
    logic              start;
    logic [NumOut*Tw-1:0] counts;
    logic              acc_clr_n;
    logic              window_active;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [Iw-1:0]     class_idx;
    logic [Tw-1:0]     class_count;
`ifdef SPIKE_READOUT_TIE_EN
    logic              class_tie;
`endif

    int errors = 0;
    int checks = 0;

    spike_count_readout #(
        .NUM_OUT     (NumOut),
        .TIMER_WIDTH (Tw),
        .WINDOW      (Win)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .counts        (counts),
        .acc_clr_n     (acc_clr_n),
        .window_active (window_active),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .class_idx     (class_idx),
        .class_count   (class_count)
`ifdef SPIKE_READOUT_TIE_EN
        ,
        .class_tie     (class_tie)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at cycle t and walk the whole inference with cycle-exact checks.
    task automatic do_inference(input string tag, input logic [Tw-1:0] c0, input logic [Tw-1:0] c1,
                                input logic [Tw-1:0] c2, input logic [Tw-1:0] c3,
                                input int exp_idx, input int exp_cnt, input int exp_tie);
        counts    = {c3, c2, c1, c0};
        out_ready = 1'b1;
        start     = 1'b1;
        tick();                                  // t+1: CLEAR
        start = 1'b0;
        check({tag, "_clr_low"}, 32'(acc_clr_n), 0);
        check({tag, "_clr_busy"}, 32'(busy), 1);
        check({tag, "_clr_win"}, 32'(window_active), 0);
        for (int c = 2; c <= 9; c++) begin       // t+2 .. t+9: RUN
            tick();
            check({tag, "_run_win"}, 32'(window_active), 1);
            check({tag, "_run_clr"}, 32'(acc_clr_n), 1);
        end
        tick();                                  // t+10: first SCAN cycle
        check({tag, "_scan_win"}, 32'(window_active), 0);
        check({tag, "_scan_busy"}, 32'(busy), 1);
        for (int c = 11; c <= 13; c++) begin
            tick();
            check({tag, "_scan_valid"}, 32'(out_valid), 0);
        end
        tick();                                  // t+14: DONE
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_idx"}, 32'(class_idx), 32'(exp_idx));
        check({tag, "_count"}, 32'(class_count), 32'(exp_cnt));
`ifdef SPIKE_READOUT_TIE_EN
        check({tag, "_tie"}, 32'(class_tie), 32'(exp_tie));
`else
        if (exp_tie > 1) check({tag, "_tie_arg"}, 32'(exp_tie), 0);
`endif
        tick();                                  // t+15: IDLE
        check({tag, "_idle_valid"}, 32'(out_valid), 0);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_hold_idx"}, 32'(class_idx), 32'(exp_idx));
        check({tag, "_hold_count"}, 32'(class_count), 32'(exp_cnt));
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        counts    = '0;
        tick();
        tick();
        check("rst_clr", 32'(acc_clr_n), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_win", 32'(window_active), 0);
        check("rst_idx", 32'(class_idx), 0);
        check("rst_count", 32'(class_count), 0);
        rstn = 1'b1;
        tick();
        check("rst_rel_clr", 32'(acc_clr_n), 1);
        check("rst_rel_busy", 32'(busy), 0);

        do_inference("argmax", 5'd3, 5'd7, 5'd2, 5'd5, 1, 7, 0);
        do_inference("tie", 5'd6, 5'd6, 5'd1, 5'd0, 0, 6, 1);
        // Every later element equals the running max of 0, so the tie flag sets.
        do_inference("zero", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        do_inference("last", 5'd30, 5'd0, 5'd0, 5'd31, 3, 31, 0);

        // Backpressure: hold DONE for 5 cycles with start pulsed.
        counts    = {5'd4, 5'd9, 5'd1, 5'd2};
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 14; c++) tick();
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_idx", 32'(class_idx), 2);
            check("bp_count", 32'(class_count), 9);
            tick();
        end
        start     = 1'b0;
        check("bp_still_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        check("bp_drop_valid", 32'(out_valid), 0);
        check("bp_idle", 32'(busy), 0);
        tick();
        check("bp_no_restart", 32'(busy), 0);
        check("bp_single_hs", 32'(out_valid), 0);

        // Reset mid-RUN at t+5.
        counts = {5'd1, 5'd1, 5'd8, 5'd1};
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        check("mr_win_before", 32'(window_active), 1);
        rstn = 1'b0;
        #1;
        check("mr_clr_now", 32'(acc_clr_n), 0);
        tick();
        check("mr_win", 32'(window_active), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_valid", 32'(out_valid), 0);
        check("mr_clr", 32'(acc_clr_n), 0);
        check("mr_idx", 32'(class_idx), 0);
        check("mr_count", 32'(class_count), 0);
        rstn = 1'b1;
        tick();
        check("mr_rel_clr", 32'(acc_clr_n), 1);
        check("mr_rel_busy", 32'(busy), 0);

        do_inference("after_rst", 5'd2, 5'd3, 5'd12, 5'd11, 2, 12, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
